// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB stage versus a 2-entry
// multi-cycle result FIFO, with starvation control and pending-rd mask.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_reg_write,
    input  logic        wb_mem_to_reg,
    input  logic [15:0] wb_alu_result,
    input  logic [15:0] wb_mem_data,
    input  logic [3:0]  wb_rd,
    input  logic        mc_valid,
    input  logic [3:0]  mc_rd,
    input  logic [15:0] mc_data,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        pipe_stall,
    output logic [15:0] pend_mask
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
    localparam logic [1:0] FULL  = 2'(FIFO_DEPTH);

    logic [1:0][3:0]  f_rd;
    logic [1:0][15:0] f_data;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [2:0]       starve_cnt;

    logic        nonempty;
    logic        fifo_grant;
    logic        pipe_grant;
    logic        push;
    logic        keep;
    logic [3:0]  head_rd;
    logic [15:0] pend_next;

    assign mc_ready   = count < FULL;
    assign nonempty   = count != 2'd0;
    assign fifo_grant = nonempty && (starve_cnt == LIMIT || !wb_reg_write);
    assign pipe_grant = wb_reg_write && !fifo_grant;
    assign pipe_stall = wb_reg_write && fifo_grant;
    assign push       = mc_valid && mc_ready;
    assign head_rd    = f_rd[rd_ptr];
    // The other slot only holds a live entry when the FIFO is full.
    assign keep       = (count == FULL) && (f_rd[~rd_ptr] == head_rd);

    always_comb begin
        pend_next = pend_mask;
        if (fifo_grant && !keep)
            pend_next[head_rd] = 1'b0;
        if (push)
            pend_next[mc_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 4'd0;
            rf_wdata   <= 16'd0;
            f_rd       <= '0;
            f_data     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            starve_cnt <= 3'd0;
            pend_mask  <= 16'd0;
        end else begin
            rf_we <= fifo_grant || pipe_grant;
            if (fifo_grant) begin
                rf_waddr <= head_rd;
                rf_wdata <= f_data[rd_ptr];
            end else if (pipe_grant) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_mem_to_reg ? wb_mem_data : wb_alu_result;
            end
            if (push) begin
                f_rd[wr_ptr]   <= mc_rd;
                f_data[wr_ptr] <= mc_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (fifo_grant)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, fifo_grant};
            if (fifo_grant || !nonempty)
                starve_cnt <= 3'd0;
            else if (pipe_grant && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 3'd1;
            pend_mask <= pend_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a queue-based
// model of the write-port arbitration rules.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_reg_write = 1'b0;
    logic        wb_mem_to_reg = 1'b0;
    logic [15:0] wb_alu_result = 16'd0;
    logic [15:0] wb_mem_data = 16'd0;
    logic [3:0]  wb_rd = 4'd0;
    logic        mc_valid = 1'b0;
    logic [3:0]  mc_rd = 4'd0;
    logic [15:0] mc_data = 16'd0;
    logic        mc_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        pipe_stall;
    logic [15:0] pend_mask;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_rd(wb_rd), .mc_valid(mc_valid), .mc_rd(mc_rd),
        .mc_data(mc_data), .mc_ready(mc_ready), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: FIFO contents as a queue of {rd, data}; starvation as an int.
    logic [19:0] q[$];
    int          m_starve;
    logic        m_we;
    logic [3:0]  m_waddr;
    logic [15:0] m_wdata;
    logic        last_stall;
    logic        saw_full;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = 16'd0;
        foreach (q[i]) m[q[i][19:16]] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        q.delete();
        m_starve = 0;
        m_we = 1'b0;
        m_waddr = 4'd0;
        m_wdata = 16'd0;
        last_stall = 1'b0;
    endtask

    task automatic step(input logic wr, input logic m2r,
                        input logic [15:0] alu, input logic [15:0] mem,
                        input logic [3:0] rd, input logic mv,
                        input logic [3:0] mrd, input logic [15:0] mdat);
        logic fg, pg, psh, ne;
        @(negedge clk);
        wb_reg_write = wr; wb_mem_to_reg = m2r;
        wb_alu_result = alu; wb_mem_data = mem; wb_rd = rd;
        mc_valid = mv; mc_rd = mrd; mc_data = mdat;
        #1;
        ne  = q.size() > 0;
        fg  = ne && (m_starve == LIMIT || !wr);
        pg  = wr && !fg;
        psh = mv && q.size() < 2;
        chk("mc_ready", 32'(mc_ready), 32'(q.size() < 2));
        chk("pipe_stall", 32'(pipe_stall), 32'(wr && fg));
        if (q.size() == 2) saw_full = 1'b1;
        last_stall = wr && fg;
        if (fg) begin
            m_we = 1'b1;
            m_waddr = q[0][19:16];
            m_wdata = q[0][15:0];
        end else if (pg) begin
            m_we = 1'b1;
            m_waddr = rd;
            m_wdata = m2r ? mem : alu;
        end else begin
            m_we = 1'b0;
        end
        if (fg || !ne) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (fg) void'(q.pop_front());
        if (psh) q.push_back({mrd, mdat});
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
        chk("pend_mask", 32'(pend_mask), 32'(model_mask()));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wb_reg_write = 1'b0; mc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_pend", 32'(pend_mask), 32'd0);
        chk("rst_ready", 32'(mc_ready), 32'd1);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic wr, m2r, mv;
        logic [15:0] alu, mem, mdat;
        logic [3:0] rd, mrd;
        model_clear();
        saw_full = 1'b0;
        #3;
        chk("init_we", 32'(rf_we), 32'd0);
        chk("init_ready", 32'(mc_ready), 32'd1);
        chk("init_pend", 32'(pend_mask), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Pipeline write selecting load data.
        step(1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'd5, 1'b0, 4'd0, 16'd0);
        chk("pipe_data", 32'(rf_wdata), 32'h0000BEEF);

        // Single multi-cycle result, no pipeline traffic.
        step(1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 4'd3, 16'h00AA);
        chk("mc_pend", 32'(pend_mask), 32'h0008);
        idle();
        chk("mc_commit", 32'({rf_we, rf_waddr, rf_wdata}), 32'({1'b1, 4'd3, 16'h00AA}));
        idle();

        // Starvation: FIFO fills while the pipeline writes every cycle.
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 16'(i), 16'd0, 4'(i), 1'b1, 4'(8 + i), 16'(16'h100 + i));
        chk("saw_full", 32'(saw_full), 32'd1);
        repeat (3) idle();

        // Duplicate rd in both FIFO slots.
        do_reset();
        step(1'b1, 1'b0, 16'd1, 16'd0, 4'd1, 1'b1, 4'd7, 16'h0071);
        step(1'b1, 1'b0, 16'd2, 16'd0, 4'd2, 1'b1, 4'd7, 16'h0072);
        idle();
        chk("dup_keep", 32'(pend_mask[7]), 32'd1);
        idle();
        chk("dup_clear", 32'(pend_mask[7]), 32'd0);

        // Pop and push in the same cycle at count 1.
        step(1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 4'd2, 16'h0222);
        step(1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 4'd9, 16'h0999);
        chk("pp_pend", 32'(pend_mask), 32'h0200);
        idle();

        // Reset with two entries buffered discards them.
        step(1'b1, 1'b0, 16'd5, 16'd0, 4'd4, 1'b1, 4'd10, 16'h0AAA);
        step(1'b1, 1'b0, 16'd6, 16'd0, 4'd4, 1'b1, 4'd11, 16'h0BBB);
        do_reset();
        repeat (3) idle();

        // Random traffic; a stalled pipeline write is re-presented.
        wr = 1'b0; m2r = 1'b0; alu = 16'd0; mem = 16'd0; rd = 4'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if (!last_stall) begin
                    wr  = 1'($urandom_range(0, 3) != 0);
                    m2r = 1'($urandom);
                    alu = 16'($urandom);
                    mem = 16'($urandom);
                    rd  = 4'($urandom);
                end
                mv   = 1'($urandom_range(0, 2) != 0);
                mrd  = 4'($urandom_range(0, 5));
                mdat = 16'($urandom);
                step(wr, m2r, alu, mem, rd, mv, mrd, mdat);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
